bit_mask_enc: RTL and testbench
===============================

# bit_mask_enc

Sequential sel-code generator that drives the `bit_mask_sel` partial-product mux in the approximate multiplier datapath. It accepts one multiplier operand per transaction and scans it two bits at a time, LSB pair first. For each pair it emits a 2-bit `sel` code, an `x`-shift flag and the pair index, one code per accepted output handshake. Downstream, the multiplicand adder tree uses these to pick 0, A, 2A or A+2A per pair.

## Interface
- `WIDTH`, 8: multiplier operand width; must be even, ≥4.
- `TRUNC`, 2: number of low pairs forced to zero code when truncation is compiled in; 0 ≤ TRUNC ≤ WIDTH/2.
- Derived constants: `NPAIR = WIDTH/2` and `IW = $clog2(NPAIR)`.
- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  block can accept an operand.
- `in_b`  in  WIDTH  multiplier operand.
- `out_valid`  out  1  code on the output is valid.
- `out_ready`  in  1  consumer takes the code.
- `out_sel`  out  2  mux select: 00 gives zero, 01 gives x, 11 gives x+y; 10 is never driven.
- `out_xshift`  out  1  x operand is 2A (1) or A (0).
- `out_idx`  out  IW  pair index; the consumer shifts the selected term left by 2·idx.
- `out_last`  out  1  current code is pair NPAIR-1.
- `busy`  out  1  a transaction is in progress.

## Operation
- Pair-to-code map, with p = {b[2i+1], b[2i]}:
  - 00 → sel 00, xshift 0
  - 01 → sel 01, xshift 0
  - 10 → sel 01, xshift 1
  - 11 → sel 11, xshift 0 (x = A, y = 2A)
- FSM states are IDLE and EMIT.
- In IDLE:
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid`, load `in_b` into the shift register, clear `idx` and go to EMIT.
- In EMIT:
  - `in_ready` = 0, `out_valid` = 1, `busy` = 1.
  - Outputs are decoded from the low 2 bits of the shift register and the `idx` register.
  - On `out_valid & out_ready`: shift the register right by 2 and increment `idx`.
  - If `out_last` was set during that handshake, return to IDLE instead.
- `in_valid` and `in_b` are ignored outside IDLE; no operand is queued.
- While `out_ready` = 0, all outputs hold stable (AXI-style; `out_valid` never drops without a handshake).
- Every transaction emits exactly NPAIR codes. Zero pairs are emitted as sel 00, never skipped.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `out_sel` 00, `out_xshift` 0, `out_idx` 0, `out_last` 0, `busy` 0, shift register 0.
- First code is valid in the cycle after the input handshake.
- Under continuous `out_ready`:
  - One code per cycle; a transaction occupies NPAIR cycles.
  - `in_ready` returns in the cycle after the last handshake.
  - Throughput is one operand per NPAIR+1 cycles.
- Reset asserted mid-EMIT clears immediately (asynchronous). The partial transaction is abandoned and `out_valid` is 0 in that same cycle.
- All outputs are driven from registers or from decode of registers; there is no combinational path from `in_*` to `out_*`.

## Configuration
- `BIT_MASK_ENC_TRUNC_EN` defined:
  - Pairs with idx < TRUNC emit sel 00 and xshift 0, whatever their bits.
  - The handshake still occurs, so the code count stays NPAIR.
  - This is the approximate-multiplier mode.
- Undefined: exact encoding for all pairs, and `TRUNC` is ignored.

## Structure
- Shared package `bit_mask_pkg` holds:
  - sel code constants `SEL_ZERO` = 2'b00, `SEL_X` = 2'b01, `SEL_XY` = 2'b11.
  - the FSM state typedef.
- Natural sub-module: `bit_mask_pair_dec`, a combinational 2-bit pair to {sel, xshift} decoder, reused by any parallel encoder variant.

## Test plan
- WIDTH=8, `in_b` = 0xE4, `out_ready` held 1 → codes (sel/xshift/idx): 00/0/0, 01/0/1, 01/1/2, 11/0/3; `out_last` set only on idx 3; `in_ready` back in the next cycle.
- 0xE4 with `out_ready` toggling 1,0,0,1,… → same four codes in order; outputs stable while stalled; no code is duplicated or dropped.
- `in_valid` pulsed with 0x55 during EMIT of 0xE4 → ignored; the 0xE4 stream completes unchanged.
- `rst` asserted after the second code of 0xFF → `out_valid` = 0 and `in_ready` = 1 immediately. The next operand 0x00 emits four 00 codes starting at idx 0.
- With `BIT_MASK_ENC_TRUNC_EN` and TRUNC=2, `in_b` = 0xFF → 00/0/0, 00/0/1, 11/0/2, 11/0/3; without the macro, four 11 codes.
- Back-to-back operands 0x01, 0x80 → 01,00,00,00 then 00,00,00,01 (xshift 1 on the last code); one idle cycle between the two streams.

Source files
------------

// File: rtl/bit_mask_pkg.sv
// bit_mask_pkg: sel code constants and FSM state type shared by the bit_mask encoder blocks.
package bit_mask_pkg;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_X    = 2'b01;
    localparam logic [1:0] SEL_XY   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_mask_pair_dec.sv
// bit_mask_pair_dec: combinational decode of one 2-bit multiplier pair into {sel, xshift}.
module bit_mask_pair_dec
    import bit_mask_pkg::*;
(
    input  logic [1:0] pair,
    output logic [1:0] sel,
    output logic       xshift
);

    // 11 selects A + 2A rather than a negative term, so no sign handling is needed
    assign sel    = (pair == 2'b00) ? SEL_ZERO : (pair == 2'b11) ? SEL_XY : SEL_X;
    assign xshift = (pair == 2'b10);

endmodule

// File: rtl/bit_mask_enc.sv
// bit_mask_enc: scans a multiplier operand two bits at a time and emits one sel code per handshake.
// Define BIT_MASK_ENC_TRUNC_EN to force the low TRUNC pairs to a zero code (approximate mode).
module bit_mask_enc
    import bit_mask_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2,
    localparam int NPAIR = WIDTH / 2,
    localparam int IW = $clog2(NPAIR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_sel,
    output logic             out_xshift,
    output logic [IW-1:0]    out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NPAIR - 1);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sh;
    logic [IW-1:0]     idx;
    logic              load, adv, emit, trunc;
    logic [1:0]        dec_sel;
    logic              dec_xshift;

    bit_mask_pair_dec u_dec (
        .pair   (sh[1:0]),
        .sel    (dec_sel),
        .xshift (dec_xshift)
    );

`ifdef BIT_MASK_ENC_TRUNC_EN
    localparam logic [IW:0] TRUNC_LIM = (IW + 1)'(TRUNC);
    assign trunc = ({1'b0, idx} < TRUNC_LIM);
`else
    assign trunc = 1'b0;
`endif

    assign emit       = (state == EMIT);
    assign in_ready   = !emit;
    assign out_valid  = emit;
    assign busy       = emit;
    assign out_sel    = (emit && !trunc) ? dec_sel : SEL_ZERO;
    assign out_xshift = emit && !trunc && dec_xshift;
    assign out_idx    = idx;
    assign out_last   = emit && (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        if (!emit) begin
            if (in_valid) begin
                state_nxt = EMIT;
                load      = 1'b1;
            end
        end else if (out_ready) begin
            adv = 1'b1;
            if (out_last) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh    <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                sh  <= in_b;
                idx <= '0;
            end else if (adv) begin
                sh  <= sh >> 2;
                idx <= out_last ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_mask_enc.sv
// tb_bit_mask_enc: randomized check of bit_mask_enc against a pair-by-pair arithmetic reference.
module tb_bit_mask_enc;

    localparam int WIDTH = 8;
    localparam int TRUNC = 2;
    localparam int NPAIR = WIDTH / 2;
    localparam int IW    = $clog2(NPAIR);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_ready, out_valid, out_xshift, out_last, busy;
    logic [1:0]       out_sel;
    logic [IW-1:0]    out_idx;

    int n_cmp = 0;
    int n_bad = 0;

    bit_mask_enc #(.WIDTH(WIDTH), .TRUNC(TRUNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .out_xshift (out_xshift),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {sel, xshift} for pair i, from the pair value as a number 0..3
    function automatic logic [2:0] ref_code(input logic [WIDTH-1:0] b, input int i);
        int p;
        p = (int'(b) >> (2 * i)) & 3;
`ifdef BIT_MASK_ENC_TRUNC_EN
        if (i < TRUNC) p = 0;
`endif
        case (p)
            0: return 3'b00_0;
            1: return 3'b01_0;
            2: return 3'b01_1;
            default: return 3'b11_0;
        endcase
    endfunction

    // stall < 0 selects the fixed ready pattern 1,0,0,1,0,0,...
    task automatic run_txn(input logic [WIDTH-1:0] b, input int stall, input bit noise);
        int k = 0;
        int cyc = 0;
        check("in_ready_idle", 32'(in_ready), 1);
        check("out_valid_idle", 32'(out_valid), 0);
        in_valid  = 1'b1;
        in_b      = b;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        while (k < NPAIR && cyc < 200) begin
            check("out_valid", 32'(out_valid), 1);
            check("in_ready_emit", 32'(in_ready), 0);
            check("busy", 32'(busy), 1);
            check("code", 32'({out_sel, out_xshift}), 32'(ref_code(b, k)));
            check("idx", 32'(out_idx), 32'(k));
            check("last", 32'(out_last), 32'(k == NPAIR - 1));
            out_ready = (stall < 0) ? (cyc % 3 == 0) : ($urandom_range(99) >= stall);
            if (noise) begin
                in_valid = 1'($urandom_range(1));
                in_b     = WIDTH'($urandom);
            end
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        if (k < NPAIR) check("timeout", 32'(k), 32'(NPAIR));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("in_ready_after", 32'(in_ready), 1);
        check("out_valid_after", 32'(out_valid), 0);
        check("busy_after", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_sel", 32'(out_sel), 0);
        check("rst_xshift", 32'(out_xshift), 0);
        check("rst_idx", 32'(out_idx), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(8'hE4, 0, 1'b0);
        run_txn(8'hE4, -1, 1'b0);
        run_txn(8'hE4, 0, 1'b1);

        in_valid = 1'b1;
        in_b     = 8'hFF;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_idx", 32'(out_idx), 2);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_idx", 32'(out_idx), 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        run_txn(8'h00, 0, 1'b0);

        run_txn(8'hFF, 0, 1'b0);
        run_txn(8'h01, 0, 1'b0);
        run_txn(8'h80, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_txn(WIDTH'($urandom), int'($urandom_range(60)), 1'($urandom_range(1)));
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
